// File: rtl/scr1_memif_pkg.sv
// Shared TCM memory-interface types: command encoding and response owner.
package scr1_memif_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_OWN_NONE = 2'd0,
    SCR1_MEM_OWN_M0   = 2'd1,
    SCR1_MEM_OWN_M1   = 2'd2
  } scr1_mem_own_e;

endpackage : scr1_memif_pkg

// File: rtl/scr1_tcm_arb.sv
// Two-master arbiter in front of TCM port B: combinational grant, one-cycle response.
// Optional m1 anti-starvation counter enabled by `SCR1_TCM_ARB_STARVE_EN.
module scr1_tcm_arb
  import scr1_memif_pkg::*;
#(
  parameter int SCR1_WIDTH      = 32,
  parameter int SCR1_AWIDTH     = 14,
  parameter int SCR1_STARVE_LIM = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    m0_req,
  input  logic                    m0_cmd,
  input  logic [SCR1_WIDTH/8-1:0] m0_be,
  input  logic [SCR1_AWIDTH-1:0]  m0_addr,
  input  logic [SCR1_WIDTH-1:0]   m0_wdata,
  output logic                    m0_ack,
  output logic                    m0_resp_vld,
  output logic [SCR1_WIDTH-1:0]   m0_rdata,

  input  logic                    m1_req,
  input  logic                    m1_cmd,
  input  logic [SCR1_WIDTH/8-1:0] m1_be,
  input  logic [SCR1_AWIDTH-1:0]  m1_addr,
  input  logic [SCR1_WIDTH-1:0]   m1_wdata,
  output logic                    m1_ack,
  output logic                    m1_resp_vld,
  output logic [SCR1_WIDTH-1:0]   m1_rdata,

  output logic                    mem_ren,
  output logic                    mem_wen,
  output logic [SCR1_WIDTH/8-1:0] mem_web,
  output logic [SCR1_AWIDTH-1:0]  mem_addr,
  output logic [SCR1_WIDTH-1:0]   mem_wdata,
  input  logic [SCR1_WIDTH-1:0]   mem_q
);

  logic          gnt_m0;
  logic          gnt_m1;
  logic          m1_boost;
  scr1_mem_own_e owner_q, owner_d;
  scr1_mem_cmd_e cmd_q, cmd_d;

`ifdef SCR1_TCM_ARB_STARVE_EN
  localparam int STARVE_CW = $clog2(SCR1_STARVE_LIM + 1);

  logic [STARVE_CW-1:0] starve_q, starve_d;

  // m1 overrides m0 only once m0 has won SCR1_STARVE_LIM contended cycles in a row
  assign m1_boost = (starve_q == STARVE_CW'(SCR1_STARVE_LIM));

  always_comb begin
    starve_d = starve_q;
    if (!m1_req || gnt_m1) starve_d = '0;
    else if (gnt_m0)       starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign m1_boost = 1'b0;
`endif

  // No grant can leak out while reset is held, even though reset is synchronous
  assign gnt_m0 = rst_n & m0_req & ~(m1_req & m1_boost);
  assign gnt_m1 = rst_n & m1_req & ~gnt_m0;

  assign m0_ack = gnt_m0;
  assign m1_ack = gnt_m1;

  always_comb begin
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_web   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_m0) begin
      mem_ren   = ~m0_cmd;
      mem_wen   = m0_cmd;
      mem_web   = m0_cmd ? m0_be : '0;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (gnt_m1) begin
      mem_ren   = ~m1_cmd;
      mem_wen   = m1_cmd;
      mem_web   = m1_cmd ? m1_be : '0;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_comb begin
    owner_d = SCR1_MEM_OWN_NONE;
    cmd_d   = SCR1_MEM_CMD_RD;
    if (gnt_m0) begin
      owner_d = SCR1_MEM_OWN_M0;
      cmd_d   = scr1_mem_cmd_e'(m0_cmd);
    end else if (gnt_m1) begin
      owner_d = SCR1_MEM_OWN_M1;
      cmd_d   = scr1_mem_cmd_e'(m1_cmd);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= SCR1_MEM_OWN_NONE;
      cmd_q   <= SCR1_MEM_CMD_RD;
    end else begin
      owner_q <= owner_d;
      cmd_q   <= cmd_d;
    end
  end

  // Gating by rst_n drops a response whose grant landed just before reset
  assign m0_resp_vld = rst_n & (owner_q == SCR1_MEM_OWN_M0);
  assign m1_resp_vld = rst_n & (owner_q == SCR1_MEM_OWN_M1);
  assign m0_rdata    = (m0_resp_vld && cmd_q == SCR1_MEM_CMD_RD) ? mem_q : '0;
  assign m1_rdata    = (m1_resp_vld && cmd_q == SCR1_MEM_CMD_RD) ? mem_q : '0;

endmodule : scr1_tcm_arb
